// File: rtl/rtlmeter_perf_pkg.sv
// Shared types and helpers for the RTLMeter performance-counter bank.
package rtlmeter_perf_pkg;

  localparam int SNAP_SEQ_W = 16;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_e;

  // Read index must reach NUM_CHANNELS, which addresses the cycle shadow.
  function automatic int idx_w(input int num_channels);
    return $clog2(num_channels + 1);
  endfunction

endpackage

// File: rtl/rtlmeter_counter_cell.sv
// One live counter with its shadow copy and sticky overflow flag.
module rtlmeter_counter_cell #(
  parameter int CNT_WIDTH = 64,
  parameter bit SATURATE  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc_i,
  input  logic                 clear_i,
  input  logic                 snap_i,
  output logic [CNT_WIDTH-1:0] shadow_o,
  output logic                 ovf_o
);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_shadow;
  logic                 r_ovf;
  logic [CNT_WIDTH-1:0] w_nxt_cnt;
  logic                 w_at_max;

  assign w_at_max = &r_cnt;

  always_comb begin
    w_nxt_cnt = r_cnt;
    if (inc_i) begin
      if (w_at_max) w_nxt_cnt = SATURATE ? r_cnt : '0;
      else          w_nxt_cnt = r_cnt + 1'b1;
    end
  end

  // Shadow takes the pre-clear next state so a clear+snap cycle keeps its events.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_shadow <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (snap_i) r_shadow <= w_nxt_cnt;
      if (clear_i) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else begin
        r_cnt <= w_nxt_cnt;
        r_ovf <= r_ovf | (inc_i & w_at_max);
      end
    end
  end

  assign shadow_o = r_shadow;
  assign ovf_o    = r_ovf;

endmodule

// File: rtl/rtlmeter_event_counters.sv
// Cycle counter plus gated event counters with snapshot shadows and a read port.
module rtlmeter_event_counters
  import rtlmeter_perf_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int CNT_WIDTH    = 64,
  parameter int SATURATE     = 0,
  parameter int INTERVAL     = 0,
  parameter int IDX_W        = idx_w(NUM_CHANNELS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic [NUM_CHANNELS-1:0] evt_i,
  input  logic                    clear_i,
  input  logic                    snap_i,
  input  logic                    rd_req_valid_i,
  output logic                    rd_req_ready_o,
  input  logic [IDX_W-1:0]        rd_req_idx_i,
  output logic                    rd_rsp_valid_o,
  input  logic                    rd_rsp_ready_i,
  output logic [CNT_WIDTH-1:0]    rd_rsp_data_o,
  output logic                    rd_rsp_err_o,
  output logic [NUM_CHANNELS:0]   ovf_o,
  output logic [SNAP_SEQ_W-1:0]   snap_seq_o
);

  localparam int TMR_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

  logic [NUM_CHANNELS:0]                w_inc;
  logic [NUM_CHANNELS:0][CNT_WIDTH-1:0] w_shadow;
  logic                                 w_snap;
  logic                                 w_tmr_fire;
  logic [TMR_W-1:0]                     r_tmr;
  logic [SNAP_SEQ_W-1:0]                r_snap_seq;

  // Top bit is the cycle counter; it counts every enabled cycle.
  assign w_inc  = {en_i, evt_i & {NUM_CHANNELS{en_i}}};
  assign w_snap = snap_i | w_tmr_fire;

  for (genvar k = 0; k <= NUM_CHANNELS; k++) begin : g_cell
    rtlmeter_counter_cell #(
      .CNT_WIDTH (CNT_WIDTH),
      .SATURATE  (SATURATE != 0)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .inc_i    (w_inc[k]),
      .clear_i  (clear_i),
      .snap_i   (w_snap),
      .shadow_o (w_shadow[k]),
      .ovf_o    (ovf_o[k])
    );
  end

  if (INTERVAL > 0) begin : g_tmr
    assign w_tmr_fire = en_i && (r_tmr == TMR_W'(INTERVAL - 1));
    always_ff @(posedge clk) begin
      if (rst || clear_i)  r_tmr <= '0;
      else if (w_tmr_fire) r_tmr <= '0;
      else if (en_i)       r_tmr <= r_tmr + 1'b1;
    end
  end else begin : g_no_tmr
    assign w_tmr_fire = 1'b0;
    always_ff @(posedge clk) r_tmr <= '0;
  end

  always_ff @(posedge clk) begin
    if (rst)         r_snap_seq <= '0;
    else if (w_snap) r_snap_seq <= r_snap_seq + 1'b1;
  end

  assign snap_seq_o = r_snap_seq;

  // Read path
  rd_state_e            r_state;
  logic [CNT_WIDTH-1:0] r_rsp_data;
  logic                 r_rsp_err;
  logic [CNT_WIDTH-1:0] w_rd_data;
  logic                 w_rd_err;
  logic                 w_req_ready;
  logic                 w_req_acc;

  always_comb begin
    w_rd_data = '0;
    for (int k = 0; k <= NUM_CHANNELS; k++)
      if (rd_req_idx_i == IDX_W'(k)) w_rd_data = w_shadow[k];
  end

  assign w_rd_err    = rd_req_idx_i > IDX_W'(NUM_CHANNELS);
  assign w_req_ready = (r_state == RD_IDLE) || rd_rsp_ready_i;
  assign w_req_acc   = rd_req_valid_i && w_req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RD_IDLE;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else if (w_req_acc) begin
      r_state    <= RD_RESP;
      r_rsp_data <= w_rd_err ? '0 : w_rd_data;
      r_rsp_err  <= w_rd_err;
    end else if (r_state == RD_RESP && rd_rsp_ready_i) begin
      r_state <= RD_IDLE;
    end
  end

  assign rd_req_ready_o = w_req_ready;
  assign rd_rsp_valid_o = (r_state == RD_RESP);
  assign rd_rsp_data_o  = r_rsp_data;
  assign rd_rsp_err_o   = r_rsp_err;

endmodule

// File: doc/rtlmeter_event_counters.md
# rtlmeter_event_counters

Synthesisable, parametrised performance-counter bank for RTLMeter benchmark harnesses. It generalises the single free-running cycle count into one cycle counter plus NUM_CHANNELS gated event counters, each selectable between wrap and saturate mode. Snapshots are taken on demand or at a fixed interval into shadow registers. Shadow values are read back over a valid/ready request/response port, so counts stay observable in emulation and FPGA flows where `final` blocks do not exist.

## Interface
- NUM_CHANNELS, 4: number of event counters (1..32).
- CNT_WIDTH, 64: width of every counter and shadow register (8..64).
- SATURATE, 0: 0 means counters wrap modulo 2^CNT_WIDTH; 1 means counters stick at all-ones.
- INTERVAL, 0: auto-snapshot period in cycles; 0 disables auto-snapshot.
- IDX_W, derived: $clog2(NUM_CHANNELS+1).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-high.
- en_i  in  1  global count enable; gates the cycle counter and all channels.
- evt_i  in  NUM_CHANNELS  per-channel event pulse; counted when en_i=1.
- clear_i  in  1  zero all live counters and overflow flags.
- snap_i  in  1  copy live counters to shadows.
- rd_req_valid_i  in  1  read request valid.
- rd_req_ready_o  out  1  read request accept.
- rd_req_idx_i  in  IDX_W  0..NUM_CHANNELS-1 selects an event shadow; NUM_CHANNELS selects the cycle shadow.
- rd_rsp_valid_o  out  1  response valid.
- rd_rsp_ready_i  in  1  response accept.
- rd_rsp_data_o  out  CNT_WIDTH  shadow value.
- rd_rsp_err_o  out  1  index out of range; data is 0.
- ovf_o  out  NUM_CHANNELS+1  sticky overflow flags; bit NUM_CHANNELS is the cycle counter.
- snap_seq_o  out  16  wrapping count of snapshots taken.

## Operation
- Cycle counter: +1 in every cycle with en_i=1.
- Channel k: +1 in every cycle with en_i=1 and evt_i[k]=1.
- Wrap mode:
  - All-ones + 1 gives 0.
  - The overflow flag for that counter sets.
- Saturate mode:
  - A counter at all-ones holds.
  - Its overflow flag sets on the first increment attempted at all-ones.
- clear_i:
  - Next state of all live counters and ovf_o is 0.
  - clear_i wins over an increment in the same cycle; that event is dropped.
  - Shadows are not cleared.
- Snapshot trigger: snap_i=1, or the interval timer expiring.
- Captured value is the counter's next-state value, including the increments from the snapshot cycle itself.
  - With clear_i in the same cycle, the capture takes the pre-clear next-state value.
- snap_seq_o increments once per snapshot cycle, even when snap_i and the timer fire together.
- Interval timer:
  - Counts en_i cycles from 0 to INTERVAL-1.
  - The snapshot fires in the cycle it holds INTERVAL-1, and the timer then returns to 0.
  - clear_i resets the timer to 0.
- Read FSM, states IDLE and RESP:
  - IDLE: rd_req_ready_o=1. On accepted valid&&ready, latch the selected shadow (or 0 with err=1 when idx > NUM_CHANNELS) into the response register and go to RESP.
  - RESP: rd_rsp_valid_o=1, with data and err stable until accepted.
  - RESP, rd_rsp_ready_i=1 and a new request valid: accept it in the same cycle and stay in RESP. This is back-to-back operation, one read per cycle.
  - RESP, rd_rsp_ready_i=1 and no new request: return to IDLE.
  - rd_req_ready_o = (state==IDLE) || rd_rsp_ready_i.
- A snapshot during RESP does not alter the pending response.

## Timing
- Reset values:
  - All counters, shadows, ovf_o, snap_seq_o and the timer are 0.
  - FSM is in IDLE: rd_req_ready_o=1, rd_rsp_valid_o=0, rd_rsp_data_o=0, rd_rsp_err_o=0.
- An event at edge t is visible in the live counter after edge t.
- Snapshot at edge t: the shadow is readable by a request accepted at edge t+1 or later.
- Read latency: response valid in the cycle after request acceptance.
- rst during RESP drops the pending response.
- No combinational path from evt_i to any output.

## Structure
- Package rtlmeter_perf_pkg:
  - the read FSM state enum;
  - the IDX_W helper function;
  - a constant for the snap_seq width (16).
- Sub-module rtlmeter_counter_cell, instantiated NUM_CHANNELS+1 times:
  - holds one live counter, its shadow and its overflow flag;
  - ports: inc, clear, snap, SATURATE parameter;
  - outputs: shadow value and ovf.
- The top level holds the interval timer, snap_seq and the read FSM/mux.

## Test plan
- Wrap/overflow, CNT_WIDTH=8, SATURATE=0: 260 cycles with en_i=1, evt_i[0] every cycle, then snap_i and read idx 0 → data 4, ovf_o[0]=1.
- Saturate, SATURATE=1, CNT_WIDTH=8: 300 events, snap, read → data 255, ovf_o[0]=1; the cycle counter also saturates at 255.
- Same-cycle events, NUM_CHANNELS=4: clear_i and snap_i asserted in the same cycle as evt_i[1], with channel 1 previously at 9:
  - shadow 1 reads 10 and live counter 1 reads 0;
  - the next snap with no events reads 0;
  - snap_seq_o=2.
- Interval snapshot, INTERVAL=5: en_i=1 for 12 cycles, with en_i low for 2 cycles in between:
  - snapshots occur in en cycles 5 and 10;
  - snap_seq_o=2;
  - the cycle shadow reads 10.
- Read handshake:
  - back-to-back requests for idx 0,1,4 with rd_rsp_ready_i=1 → three responses on consecutive cycles;
  - rd_rsp_ready_i held low for 3 cycles → data stable and rd_req_ready_o=0;
  - idx 7 with NUM_CHANNELS=4 → err=1, data 0.
- Reset mid-read: rst asserted while in RESP → next cycle rd_rsp_valid_o=0, rd_req_ready_o=1, all counters 0.
